// File: rtl/clock_switch_controller_if.sv
// Request/status bundle between a clock-switch requester and the controller.
// The toggle inputs and liveness flags travel with it so the mux side sees one port.
interface clock_switch_controller_if;
    logic req_valid;
    logic req_sel;
    logic req_ready;
    logic tgl_0;
    logic tgl_1;
    logic sel;
    logic busy;
    logic done;
    logic err;
    logic alive_0;
    logic alive_1;

    // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
    // req_sel is sampled on that edge, and req_valid while req_ready=0 is dropped, not queued.
    modport master (
        output req_valid, req_sel, tgl_0, tgl_1,
        input  req_ready, sel, busy, done, err, alive_0, alive_1
    );

    modport slave (
        input  req_valid, req_sel, tgl_0, tgl_1,
        output req_ready, sel, busy, done, err, alive_0, alive_1
    );
endinterface

// File: rtl/clock_switch_controller.sv
// Drives the glitch-free mux select only after the target source shows activity,
// then waits a guard interval before reporting done; also publishes source liveness.
module clock_switch_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int WINDOW      = 64,
    parameter int MIN_TICKS   = 4,
    parameter int GUARD       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    clock_switch_controller_if.slave   bus,
    output logic [1:0]                 state_o
);
    localparam int WW = $clog2(WINDOW);
    localparam int CW = $clog2(MIN_TICKS + 1);
    localparam int GW = $clog2(GUARD + 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [CW-1:0] TICKS_MAX  = CW'(MIN_TICKS);
    localparam logic [CW-1:0] TICKS_PRE  = CW'(MIN_TICKS - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, SWITCH = 2'd2} state_t;

    logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
    logic                   prev0_q, prev1_q;
    logic                   tick0, tick1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
            prev0_q <= 1'b0;
            prev1_q <= 1'b0;
        end else begin
            sync0_q <= {sync0_q[SYNC_STAGES-2:0], bus.tgl_0};
            sync1_q <= {sync1_q[SYNC_STAGES-2:0], bus.tgl_1};
            prev0_q <= sync0_q[SYNC_STAGES-1];
            prev1_q <= sync1_q[SYNC_STAGES-1];
        end
    end

    assign tick0 = sync0_q[SYNC_STAGES-1] ^ prev0_q;
    assign tick1 = sync1_q[SYNC_STAGES-1] ^ prev1_q;

    // Free-running liveness monitor; tick counts saturate so they never wrap.
    logic [WW-1:0] mon_win_q;
    logic [CW-1:0] cnt0_q, cnt1_q, cnt0_d, cnt1_d;
    logic          alive0_q, alive1_q;

    always_comb begin
        cnt0_d = (tick0 && cnt0_q != TICKS_MAX) ? cnt0_q + CW'(1) : cnt0_q;
        cnt1_d = (tick1 && cnt1_q != TICKS_MAX) ? cnt1_q + CW'(1) : cnt1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mon_win_q <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            alive0_q  <= 1'b0;
            alive1_q  <= 1'b0;
        end else if (mon_win_q == WIN_LAST) begin
            mon_win_q <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            alive0_q  <= (cnt0_d == TICKS_MAX);
            alive1_q  <= (cnt1_d == TICKS_MAX);
        end else begin
            mon_win_q <= mon_win_q + WW'(1);
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    state_t        state_q, state_d;
    logic          sel_q, sel_d, target_q, target_d;
    logic          done_q, done_d, err_q, err_d;
    logic [CW-1:0] chk_cnt_q, chk_cnt_d;
    logic [WW-1:0] chk_win_q, chk_win_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          tick_t;

    assign tick_t = target_q ? tick1 : tick0;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        target_d  = target_q;
        chk_cnt_d = chk_cnt_q;
        chk_win_d = chk_win_q;
        guard_d   = guard_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = CHECK;
                        target_d  = bus.req_sel;
                        chk_cnt_d = '0;
                        chk_win_d = '0;
                    end
                end
            end
            CHECK: begin
                // Success is tested first so a completing tick on the last window cycle wins.
                if (tick_t && chk_cnt_q == TICKS_PRE) begin
                    state_d = SWITCH;
                    sel_d   = target_q;
                    guard_d = '0;
                end else if (chk_win_q == WIN_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    chk_win_d = chk_win_q + WW'(1);
                    if (tick_t) chk_cnt_d = chk_cnt_q + CW'(1);
                end
            end
            SWITCH: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            target_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            chk_cnt_q <= '0;
            chk_win_q <= '0;
            guard_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            target_q  <= target_d;
            done_q    <= done_d;
            err_q     <= err_d;
            chk_cnt_q <= chk_cnt_d;
            chk_win_q <= chk_win_d;
            guard_q   <= guard_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sel       = sel_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.alive_0   = alive0_q;
    assign bus.alive_1   = alive1_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_clock_switch_controller.sv
// Bench for clock_switch_controller: records every cycle of each scenario, then
// derives expected outputs from request/tick history with an event-level model.
module tb_clock_switch_controller;
  localparam int SYNC_STAGES = 2;
  localparam int WINDOW      = 64;
  localparam int MIN_TICKS   = 4;
  localparam int GUARD       = 16;
  localparam int MAXC        = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_o;

  clock_switch_controller_if bus();

  clock_switch_controller #(
    .SYNC_STAGES(SYNC_STAGES), .WINDOW(WINDOW), .MIN_TICKS(MIN_TICKS), .GUARD(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // per-cycle recording: inputs seen at the edge, outputs 1 ns after it
  bit         rec_en = 1'b0;
  int         cyc = 0;
  bit         rv_h [MAXC];
  bit         rs_h [MAXC];
  bit         t0_h [MAXC];
  bit         t1_h [MAXC];
  logic [6:0] out_h [MAXC];

  always @(posedge clk) begin
    if (!rec_en) begin
      cyc = 0;
    end else if (cyc < MAXC) begin
      rv_h[cyc] = bus.req_valid;
      rs_h[cyc] = bus.req_sel;
      t0_h[cyc] = bus.tgl_0;
      t1_h[cyc] = bus.tgl_1;
      #1;
      out_h[cyc] = {bus.alive_1, bus.alive_0, bus.sel, bus.req_ready, bus.busy, bus.done, bus.err};
      cyc++;
    end
  end

  // driver tasks
  int per0 = 0, per1 = 0, ph0 = 0, ph1 = 0;

  task automatic step();
    @(negedge clk);
    if (per0 > 0) begin
      if (ph0 >= per0 - 1) begin bus.tgl_0 = ~bus.tgl_0; ph0 = 0; end else ph0++;
    end
    if (per1 > 0) begin
      if (ph1 >= per1 - 1) begin bus.tgl_1 = ~bus.tgl_1; ph1 = 0; end else ph1++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_req(input bit s);
    step();
    bus.req_valid = 1'b1;
    bus.req_sel   = s;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic flip1();
    bus.tgl_1 = ~bus.tgl_1;
  endtask

  task automatic do_reset();
    rec_en = 1'b0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    idle(3);
    step();
    rst = 1'b0;
    rec_en = 1'b1;
  endtask

  // reference model: a source tick seen at edge m is a level change of the
  // sampled toggle SYNC_STAGES edges earlier (history before reset reads as 0)
  function automatic bit tick_at(input bit ch, input int m, input int n);
    int a, b;
    bit va, vb;
    a = m - SYNC_STAGES;
    b = a - 1;
    if (a < 0 || a >= n) return 1'b0;
    va = ch ? t1_h[a] : t0_h[a];
    vb = (b < 0) ? 1'b0 : (ch ? t1_h[b] : t0_h[b]);
    return va ^ vb;
  endfunction

  bit         e_flip [MAXC];
  bit         e_done [MAXC];
  bit         e_err  [MAXC];
  bit         e_busy [MAXC];
  logic [6:0] exp_q[$];

  task automatic check_segment(input string tag, input int n);
    bit msel, cur_sel, al0, al1;
    int free_at, e_sw, cnt, c0, c1;
    for (int m = 0; m < n; m++) begin
      e_flip[m] = 0; e_done[m] = 0; e_err[m] = 0; e_busy[m] = 0;
    end
    msel = 0;
    free_at = 0;
    for (int m = 0; m < n; m++) begin
      if (m >= free_at && rv_h[m]) begin
        if (rs_h[m] == msel) begin
          e_done[m] = 1;
          free_at = m + 1;
        end else begin
          e_sw = -1;
          cnt = 0;
          for (int k = 1; k <= WINDOW; k++) begin
            if (tick_at(rs_h[m], m + k, n)) begin
              cnt++;
              if (cnt == MIN_TICKS) begin e_sw = m + k; break; end
            end
          end
          if (e_sw >= 0) begin
            for (int j = m; j < e_sw + GUARD && j < n; j++) e_busy[j] = 1;
            if (e_sw < n) e_flip[e_sw] = 1;
            if (e_sw + GUARD < n) e_done[e_sw + GUARD] = 1;
            msel = rs_h[m];
            free_at = e_sw + GUARD + 1;
          end else begin
            for (int j = m; j < m + WINDOW && j < n; j++) e_busy[j] = 1;
            if (m + WINDOW < n) e_err[m + WINDOW] = 1;
            free_at = m + WINDOW + 1;
          end
        end
      end
    end
    cur_sel = 0; al0 = 0; al1 = 0;
    for (int m = 0; m < n; m++) begin
      if (e_flip[m]) cur_sel = ~cur_sel;
      if (m % WINDOW == WINDOW - 1) begin
        c0 = 0; c1 = 0;
        for (int j = m - WINDOW + 1; j <= m; j++) begin
          if (tick_at(1'b0, j, n)) c0++;
          if (tick_at(1'b1, j, n)) c1++;
        end
        al0 = (c0 >= MIN_TICKS);
        al1 = (c1 >= MIN_TICKS);
      end
      exp_q.push_back({al1, al0, cur_sel, ~e_busy[m], e_busy[m], e_done[m], e_err[m]});
    end
    for (int m = 0; m < n; m++) begin
      check($sformatf("%s@%0d", tag, m), {1'b0, out_h[m]}, {1'b0, exp_q.pop_front()});
    end
  endtask

  task automatic finish_seg(input string tag);
    int n;
    step();
    rec_en = 1'b0;
    n = cyc;
    check_segment(tag, n);
  endtask

  initial begin
    int w;
    bus.req_valid = 1'b0;
    bus.req_sel   = 1'b0;
    bus.tgl_0     = 1'b0;
    bus.tgl_1     = 1'b0;
    #2;
    check("rst_sel",    bus.sel,       1'b0);
    check("rst_ready",  bus.req_ready, 1'b1);
    check("rst_busy",   bus.busy,      1'b0);
    check("rst_done",   bus.done,      1'b0);
    check("rst_err",    bus.err,       1'b0);
    check("rst_alive0", bus.alive_0,   1'b0);
    check("rst_alive1", bus.alive_1,   1'b0);

    // successful switch to clk_1 toggling every 4 cycles
    per0 = 0; per1 = 4;
    do_reset();
    idle(5);
    send_req(1'b1);
    idle(120);
    finish_seg("switch");

    // dead target: timeout error
    per1 = 0;
    do_reset();
    send_req(1'b1);
    idle(90);
    finish_seg("dead");

    // request for the current source
    do_reset();
    send_req(1'b0);
    idle(5);
    send_req(1'b0);
    idle(5);
    finish_seg("same");

    // requests while busy are dropped
    per1 = 5;
    do_reset();
    send_req(1'b1);
    idle(6);
    send_req(1'b0);
    idle(3);
    send_req(1'b1);
    idle(100);
    finish_seg("ignore");

    // 4th tick on the final check-window cycle succeeds
    per1 = 0;
    bus.tgl_1 = 1'b0;
    do_reset();
    idle(3);
    send_req(1'b1);
    idle(13); flip1();
    idle(16); flip1();
    idle(16); flip1();
    idle(16); flip1();
    idle(40);
    finish_seg("edge_ok");

    // one cycle later is a timeout
    bus.tgl_1 = 1'b0;
    do_reset();
    idle(3);
    send_req(1'b1);
    idle(13); flip1();
    idle(16); flip1();
    idle(16); flip1();
    idle(17); flip1();
    idle(40);
    finish_seg("edge_late");

    // liveness: clk_0 runs then stops, clk_1 stopped
    per0 = 3; per1 = 0;
    do_reset();
    idle(200);
    per0 = 0;
    idle(200);
    finish_seg("alive");

    // randomized traffic and source activity
    per0 = $urandom_range(0, 6);
    per1 = $urandom_range(0, 6);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) per1 = $urandom_range(0, 20);
      if ($urandom_range(0, 3) == 0) per0 = $urandom_range(0, 20);
      send_req(1'($urandom_range(0, 1)));
    end
    idle(100);
    finish_seg("random");

    // reset in the guard interval
    per0 = 0; per1 = 4;
    do_reset();
    send_req(1'b1);
    w = 0;
    while (bus.sel !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    check("sel_rise_wait", (w < 100), 1'b1);
    idle(4);
    rec_en = 1'b0;
    check_segment("pre_abort", cyc);
    #2;
    rst = 1'b1;
    #1;
    check("abort_sel",   bus.sel,       1'b0);
    check("abort_busy",  bus.busy,      1'b0);
    check("abort_ready", bus.req_ready, 1'b1);
    check("abort_state", state_o,       2'd0);
    idle(2);
    rst = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
